// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo note player.
// - state_e    : player FSM states.
// - NOTE_REST  : note index that plays silence.
// - F_*_MHZ    : note frequencies in millihertz.
// - half_period: rounded clock count for half a cycle of a tone.
package piezo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  localparam int NOTE_REST = 0;

  // Frequencies are held in millihertz so that the integer rounding
  // below still gives round(CLK_HZ / (2 * f)) for non-integer pitches.
  localparam longint unsigned F_C4_MHZ = 64'd261626;
  localparam longint unsigned F_D4_MHZ = 64'd293665;
  localparam longint unsigned F_E4_MHZ = 64'd329628;
  localparam longint unsigned F_F4_MHZ = 64'd349228;
  localparam longint unsigned F_G4_MHZ = 64'd391995;
  localparam longint unsigned F_A4_MHZ = 64'd440000;
  localparam longint unsigned F_B4_MHZ = 64'd493883;
  localparam longint unsigned F_C5_MHZ = 64'd523251;

  // round(clk_hz / (2 * f)), with f given in millihertz.
  function automatic longint unsigned half_period(input longint unsigned clk_hz,
                                                  input longint unsigned f_mhz);
    if (f_mhz == 64'd0) begin
      return 64'd0;
    end
    return (clk_hz * 64'd1000 + f_mhz) / (64'd2 * f_mhz);
  endfunction

endpackage

// File: rtl/piezo_note_rom.sv
// Combinational note table: note index -> half-period count in clocks.
// Index 0 is a rest and indices above 8 are also treated as rests
// (half period 0).
// Ports:
//   note_i  [NOTE_W-1:0]  note index
//   half_o  [HALF_W-1:0]  half-period count, 0 for a rest
module piezo_note_rom
  import piezo_pkg::*;
#(
  parameter int CLK_HZ = 1_000_000,
  parameter int HALF_W = 16,
  parameter int NOTE_W = 4
) (
  input  logic [NOTE_W-1:0] note_i,
  output logic [HALF_W-1:0] half_o
);

  localparam logic [HALF_W-1:0] H_C4 = HALF_W'(half_period(64'(CLK_HZ), F_C4_MHZ));
  localparam logic [HALF_W-1:0] H_D4 = HALF_W'(half_period(64'(CLK_HZ), F_D4_MHZ));
  localparam logic [HALF_W-1:0] H_E4 = HALF_W'(half_period(64'(CLK_HZ), F_E4_MHZ));
  localparam logic [HALF_W-1:0] H_F4 = HALF_W'(half_period(64'(CLK_HZ), F_F4_MHZ));
  localparam logic [HALF_W-1:0] H_G4 = HALF_W'(half_period(64'(CLK_HZ), F_G4_MHZ));
  localparam logic [HALF_W-1:0] H_A4 = HALF_W'(half_period(64'(CLK_HZ), F_A4_MHZ));
  localparam logic [HALF_W-1:0] H_B4 = HALF_W'(half_period(64'(CLK_HZ), F_B4_MHZ));
  localparam logic [HALF_W-1:0] H_C5 = HALF_W'(half_period(64'(CLK_HZ), F_C5_MHZ));

  always_comb begin
    half_o = '0;
    case (note_i)
      NOTE_W'(NOTE_REST): half_o = '0;
      NOTE_W'(1):         half_o = H_C4;
      NOTE_W'(2):         half_o = H_D4;
      NOTE_W'(3):         half_o = H_E4;
      NOTE_W'(4):         half_o = H_F4;
      NOTE_W'(5):         half_o = H_G4;
      NOTE_W'(6):         half_o = H_A4;
      NOTE_W'(7):         half_o = H_B4;
      NOTE_W'(8):         half_o = H_C5;
      default:            half_o = '0;
    endcase
  end

endmodule

// File: rtl/piezo_note_player.sv
// Piezo note player: accepts a note request (NOTE, DUR), plays a square
// wave on PIEZO for DUR ticks of TICK_DIV clocks each, then pulses DONE.
//
// Handshake: REQ_READY = IDLE & EN & RST; a request transfers at any rising
// CLK edge where REQ_VALID and REQ_READY are both high. REQ_READY does not
// depend on REQ_VALID, and it is high during the DONE cycle, so a held
// request is taken back-to-back.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous reset, active-low
//   EN         enable; low pauses playback and blocks acceptance
//   NOTE       note index (0 = rest, >= 9 = rest)
//   DUR        duration in ticks (0 = complete immediately)
//   REQ_VALID  request valid
//   REQ_READY  request ready
//   PIEZO      square-wave output
//   BUSY       high while playing
//   DONE       one-cycle pulse when a note completes
// The FSM state is kept in state_q (type state_e) for observation.
module piezo_note_player
  import piezo_pkg::*;
#(
  parameter int CLK_HZ   = 1_000_000,
  parameter int HALF_W   = 16,
  parameter int NOTE_W   = 4,
  parameter int DUR_W    = 12,
  parameter int TICK_DIV = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [NOTE_W-1:0] NOTE,
  input  logic [DUR_W-1:0]  DUR,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  output logic              PIEZO,
  output logic              BUSY,
  output logic              DONE
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e              state_q;
  logic [HALF_W-1:0]   half_q;
  logic [HALF_W-1:0]   cnt_q;
  logic [TICK_W-1:0]   tick_q;
  logic [DUR_W-1:0]    dur_q;
  logic                phase_q;
  logic                piezo_q;
  logic                busy_q;
  logic                done_q;
  logic [HALF_W-1:0]   rom_half;

  piezo_note_rom #(
    .CLK_HZ (CLK_HZ),
    .HALF_W (HALF_W),
    .NOTE_W (NOTE_W)
  ) u_rom (
    .note_i (NOTE),
    .half_o (rom_half)
  );

  assign REQ_READY = (state_q == IDLE) & EN & RST;
  assign PIEZO     = piezo_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      half_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      phase_q <= 1'b0;
      piezo_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            half_q  <= rom_half;
            dur_q   <= DUR;
            cnt_q   <= '0;
            tick_q  <= '0;
            phase_q <= 1'b0;
            piezo_q <= 1'b0;
            if (DUR == '0) begin
              // Zero-length note: report completion without playing.
              done_q <= 1'b1;
            end else begin
              state_q <= PLAY;
              busy_q  <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (EN) begin
            // Tone generator; a zero half period is a rest and stays silent.
            if (half_q != '0) begin
              if (cnt_q == half_q - HALF_W'(1)) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
                piezo_q <= ~phase_q;
              end else begin
                cnt_q   <= cnt_q + HALF_W'(1);
                piezo_q <= phase_q;
              end
            end else begin
              piezo_q <= 1'b0;
            end
            // Duration timer; the last tick of the last unit ends the note.
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              dur_q  <= dur_q - DUR_W'(1);
              if (dur_q == DUR_W'(1)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                phase_q <= 1'b0;
                piezo_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
          end else begin
            // Paused: counters and phase hold, output is silenced.
            piezo_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/piezo_note_player.md
Name: piezo_note_player

Overview:
Parametrised successor to the fixed piezo clock divider. It accepts note requests over a valid/ready handshake and looks up a half-period count from a note table. It drives a square wave on PIEZO for a programmed duration, in ticks of TICK_DIV clocks, then pulses DONE. It sits between the launchpad key/sequencer logic and the piezo pin, and adds rests, pause and per-note duration.

Parameters:
CLK_HZ, 1_000_000, input clock frequency; the note table is derived from it.
HALF_W, 16, width of the half-period counter.
NOTE_W, 4, width of the note index.
DUR_W, 12, width of the duration field, in ticks.
TICK_DIV, 1000, clocks per duration tick (1 ms at the default CLK_HZ).

Ports:
CLK        in   1       system clock, rising edge
RST        in   1       synchronous reset, active-low
EN         in   1       enable; low pauses playback and blocks acceptance
NOTE       in   NOTE_W  note index; 0 = rest
DUR        in   DUR_W   duration in ticks
REQ_VALID  in   1       request valid
REQ_READY  out  1       request ready
PIEZO      out  1       square-wave output to the piezo
BUSY       out  1       high while in PLAY
DONE       out  1       one-cycle pulse when a note completes

Behaviour:
- Reset (RST low at an edge): state=IDLE, PIEZO=0, BUSY=0, DONE=0, all counters 0. REQ_READY=0 while RST is low. Reset mid-note aborts the note and produces no DONE.
- REQ_READY = (state==IDLE) & EN & RST. A request is accepted at an edge where REQ_VALID & REQ_READY.
- On accept at edge k:
  - latch H = table[NOTE] and dur_left = DUR;
  - set cnt=0, tick=0, PIEZO=0.
  - If DUR==0: stay in IDLE and set DONE=1 on cycle k+1.
  - Else: go to PLAY and set BUSY=1.
- PLAY, at each edge with EN=1:
  - Tone: if H==0 (rest), PIEZO stays 0. Else if cnt==H-1, toggle the phase and set cnt=0; otherwise cnt+1. The first rising toggle is at edge k+H, and the period is 2H clocks.
  - Duration: if tick==TICK_DIV-1, set tick=0 and decrement dur_left; otherwise tick+1.
  - Completion: at the edge where tick==TICK_DIV-1 and dur_left==1, go to IDLE with PIEZO=0, BUSY=0, and DONE=1 for exactly the next cycle.
  - Total time in PLAY is DUR*TICK_DIV clocks.
- PLAY with EN=0 (pause): cnt, tick, dur_left and the phase all hold. PIEZO is forced to 0 and BUSY stays 1. On resume, the output restores the held phase and counting continues with no cycles lost.
- Back-to-back: REQ_READY is high during the DONE cycle, so a new accept may coincide with DONE. DONE still pulses once for the finished note.
- NOTE >= 9 is treated as a rest (H=0). A rest request still times DUR ticks and pulses DONE.
- Arithmetic: all counters are unsigned. Comparisons use full widths. Counters never wrap because the resets above always occur first. The half-period comparison uses H-1 computed in HALF_W bits and is only evaluated when H!=0.
- Note table at CLK_HZ=1e6, each entry round(CLK_HZ/(2f)): 1 C4=1911, 2 D4=1703, 3 E4=1517, 4 F4=1432, 5 G4=1276, 6 A4=1136, 7 B4=1012, 8 C5=956.

Decomposition:
- Package piezo_pkg holds:
  - state enum {IDLE, PLAY};
  - the note frequency constants and the NOTE_REST=0 constant;
  - the function computing half-period counts from CLK_HZ.
- Sub-module piezo_note_rom holds the combinational lookup NOTE -> H (HALF_W bits), parametrised by CLK_HZ.
- The top level holds the FSM and the cnt, tick and dur_left counters.

Test Plan:
- Bench parameters: TICK_DIV=10, CLK_HZ=1e6.
- Reset: hold RST=0 for 2 clocks while REQ_VALID=1 -> REQ_READY=0, PIEZO=0, BUSY=0, DONE=0, and no accept.
- NOTE=8, DUR=200, accept at edge k -> PIEZO rises at k+956 and falls at k+1912. BUSY falls and DONE=1 at cycle k+2001, with DONE lasting exactly 1 cycle.
- NOTE=0, DUR=3 -> PIEZO stays 0, BUSY is high for 30 cycles, then one DONE pulse. NOTE=12 gives the identical response.
- DUR=0 with any NOTE -> no PLAY (BUSY stays 0) and DONE=1 on the next cycle.
- NOTE=8, DUR=200, EN=0 for 50 cycles starting at k+500 -> PIEZO=0 during the pause. The rise moves to k+1006 and DONE moves to k+2051.
- RST=0 at k+100 during PLAY -> state=IDLE, PIEZO=0, no DONE. Two back-to-back requests held with REQ_VALID=1 -> the second is accepted in the DONE cycle.
